// File: rtl/gb_bus_sync.sv
// gb_bus_sync: synchronise the asynchronous GB cartridge bus and turn each genuine WR pulse into one write strobe.
// Ports: clk/rst_n (async active-low); gb_addr_hi, gb_data, gb_write_n, gb_read_n, cs_n raw bus inputs;
// wr_strobe/wr_addr/wr_data accepted write; rd_active synchronised read; ram_sel synchronised select;
// wr_timeout sticky watchdog flag (only built with GB_BUS_WATCHDOG_EN, otherwise tied 0).
module gb_bus_sync #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] gb_addr_hi,
    input  logic [7:0] gb_data,
    input  logic       gb_write_n,
    input  logic       gb_read_n,
    input  logic       cs_n,
    output logic       wr_strobe,
    output logic [2:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_active,
    output logic       ram_sel,
    output logic       wr_timeout
);
    typedef enum logic [1:0] {S_IDLE, S_QUAL, S_ACTIVE, S_RELEASE} state_t;
    // bus idle level: WR/RD/CS high, address and data low
    localparam logic [13:0] BUS_IDLE = {3'b111, 11'd0};
    localparam logic [3:0]  FILT     = 4'(FILTER_CYCLES);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_CYCLES < 1 || FILTER_CYCLES > 15 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("gb_bus_sync: parameter out of range");
    end

    logic [13:0] sync_q [SYNC_STAGES];
    logic        s_wr_n, s_rd_n, s_cs_n;
    logic [2:0]  s_addr;
    logic [7:0]  s_data;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, cnt_inc;
    logic [10:0] shadow_q, out_q;
    logic        strobe_q, fire, wd_hit, blk;

    assign {s_wr_n, s_rd_n, s_cs_n, s_addr, s_data} = sync_q[SYNC_STAGES-1];
    assign cnt_inc = (cnt_q == FILT) ? FILT : cnt_q + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= BUS_IDLE;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            out_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            sync_q[0] <= {gb_write_n, gb_read_n, cs_n, gb_addr_hi, gb_data};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            // every low-phase sample overwrites the shadow, so the last one before release wins
            if (!s_wr_n) shadow_q <= {s_addr, s_data};
            if (fire) out_q <= shadow_q;
            strobe_q <= fire;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        case (state_q)
            S_IDLE:
                if (!s_wr_n && !blk) begin
                    cnt_d   = 4'd1;
                    state_d = (FILT == 4'd1) ? S_ACTIVE : S_QUAL;
                end
            S_QUAL:
                if (s_wr_n) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == FILT) state_d = S_ACTIVE;
                end
            S_ACTIVE:
                if (s_wr_n) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end
            default:
                if (!s_wr_n) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                end else if (cnt_inc == FILT) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
        endcase
        if (wd_hit) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            fire    = 1'b0;
        end
    end

`ifdef GB_BUS_WATCHDOG_EN
    logic [15:0] wd_q;
    logic        to_q, blk_q;
    logic        busy;
    assign busy   = (state_q == S_QUAL) || (state_q == S_ACTIVE);
    assign wd_hit = busy && (wd_q + 16'd1 == 16'(TIMEOUT_CYCLES));
    assign blk    = blk_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            to_q  <= 1'b0;
            blk_q <= 1'b0;
        end else begin
            // runs through QUAL/ACTIVE, frozen across a release bounce, cleared back in IDLE
            wd_q  <= busy ? wd_q + 16'd1 : (state_q == S_IDLE) ? '0 : wd_q;
            to_q  <= to_q | wd_hit;
            // after a timeout, a stuck-low WR must be seen high before a new write may start
            blk_q <= wd_hit | (blk_q & ~s_wr_n);
        end
    end
`else
    assign wd_hit = 1'b0;
    assign blk    = 1'b0;
`endif

    always_comb begin
        wr_strobe          = strobe_q;
        {wr_addr, wr_data} = out_q;
        rd_active          = ~s_rd_n & (state_q == S_IDLE);
        ram_sel            = ~s_cs_n;
`ifdef GB_BUS_WATCHDOG_EN
        wr_timeout         = to_q;
`else
        wr_timeout         = 1'b0;
`endif
    end
endmodule

// File: doc/gb_bus_sync.md
Name: gb_bus_sync

Overview:
- Front-end stage directly upstream of the MBC register file.
- Synchronises the asynchronous Game Boy cartridge bus (upper address, data, WR/RD, CS) into the cartridge clock domain and glitch-filters WR.
- Emits exactly one single-cycle write strobe per genuine GB write, carrying the stable address and data.
- The MBC bank/enable/mode registers then update synchronously from that strobe instead of from combinational bus edges.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on every bus input; legal range 2-4.
- FILTER_CYCLES, 3: consecutive synchronised cycles a WR level must hold to be accepted; legal range 1-15.
- TIMEOUT_CYCLES, 255: maximum cycles WR may stay asserted; used only when GB_BUS_WATCHDOG_EN is defined; range 1-65535.

Ports:
- clk  in  1  cartridge clock, at least 4x GB bus rate.
- rst_n  in  1  asynchronous active-low reset.
- gb_addr_hi  in  3  GB A15..A13, asynchronous.
- gb_data  in  8  GB D7..D0, asynchronous.
- gb_write_n  in  1  GB WR, active low, asynchronous.
- gb_read_n  in  1  GB RD, active low, asynchronous.
- cs_n  in  1  GB external-RAM select, active low, asynchronous.
- wr_strobe  out  1  one-cycle pulse per accepted write.
- wr_addr  out  3  A15..A13 of the accepted write; valid while wr_strobe=1, held afterwards.
- wr_data  out  8  data of the accepted write; valid while wr_strobe=1, held afterwards.
- rd_active  out  1  synchronised read in progress: RD low and write FSM in IDLE.
- ram_sel  out  1  synchronised and inverted cs_n.
- wr_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset
  - Asynchronous assert on rst_n=0.
  - All synchroniser flops reset to the bus idle level: WR/RD/CS = 1; address and data = 0.
  - Outputs reset to: wr_strobe=0, wr_addr=0, wr_data=0x00, rd_active=0, ram_sel=0, wr_timeout=0.
  - FSM resets to IDLE; filter counter resets to 0.
- Synchronisation
  - Every input passes through SYNC_STAGES flops; all logic below uses only synchronised values (s_wr_n, s_addr, s_data, s_rd_n, s_cs_n).
- Filter counter
  - Counts consecutive cycles in which s_wr_n matches the level the FSM is waiting for.
  - Clears on any mismatch.
  - Saturates at FILTER_CYCLES.
- FSM states
  - IDLE: wait for s_wr_n=0. Then go to QUAL with counter=1.
  - QUAL: s_wr_n returns to 1 before counter reaches FILTER_CYCLES: glitch, back to IDLE, no strobe. Counter reaches FILTER_CYCLES: go to ACTIVE.
  - ACTIVE: capture s_addr and s_data into shadow registers every cycle, so the last low-phase sample wins. s_wr_n=1: go to RELEASE.
  - RELEASE: s_wr_n=1 for FILTER_CYCLES consecutive cycles: copy shadow to wr_addr/wr_data, assert wr_strobe for exactly one cycle, go to IDLE. s_wr_n=0 before that: return to ACTIVE (bounce), no strobe.
- Latency: wr_strobe rises SYNC_STAGES + FILTER_CYCLES + 1 cycles after the raw WR rising edge.
- Every accepted write produces exactly one strobe, irrespective of how long WR is held.
- The strobe is never re-issued while WR stays high.
- Address and data are presented as captured; decoding of A15..A13 belongs to the MBC.
- rd_active = ~s_rd_n, gated to 0 while the FSM is not in IDLE. Simultaneous RD and WR: the write takes priority.
- ram_sel = ~s_cs_n, combinational from synchroniser outputs.
- Reset mid-write
  - FSM returns to IDLE, no strobe.
  - After reset release with WR still low, the write is qualified normally (IDLE → QUAL) and does produce a strobe.

Optional Feature:
- Macro GB_BUS_WATCHDOG_EN.
- Defined:
  - A 16-bit counter runs while in QUAL/ACTIVE.
  - Reaching TIMEOUT_CYCLES forces IDLE without a strobe, sets wr_timeout (sticky until rst_n), and blocks re-entry into QUAL until s_wr_n=1 has been seen.
- Not defined:
  - No counter is built; wr_timeout is tied to 0.
  - A stuck WR simply holds the FSM in ACTIVE.

Test Plan:
- Write A=3'b001, D=0x05, WR low 8 cycles: exactly one wr_strobe, wr_addr=3'b001, wr_data=0x05, latency 6 cycles from WR rise (defaults).
- WR low pulse of 2 cycles (FILTER_CYCLES=3): no strobe; outputs hold previous values.
- WR low 10 cycles with a 1-cycle high bounce at cycle 5, data changing 0x0A→0x00 before release: one strobe, wr_data=0x00.
- RD low while idle: rd_active=1 after 2 cycles. WR asserted during that RD: rd_active drops to 0 once the FSM leaves IDLE; strobe still issued.
- rst_n pulsed low during ACTIVE, WR still low afterwards: no strobe during reset; after release, one strobe on WR rise.
- GB_BUS_WATCHDOG_EN, TIMEOUT_CYCLES=20, WR held low 40 cycles: wr_timeout=1 at about cycle 20, no strobe on WR rise, next normal write strobes correctly.
